// File: rtl/aes_pkg.sv
// Shared AES arithmetic (GF(2^8), S-box, Rcon) and the FSM state type for the iterative core.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 (zero maps to zero), then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 2; i < 16; i++) begin
      if (i <= int'(n)) r = xtime(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] result
);

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [127:0] shifted;
  logic [127:0] mixed;

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    shifted = '0;
    mixed   = '0;
    for (int n = 0; n < 16; n++) sb[n] = sbox(state[127-8*n -: 8]);
    // byte n sits at row n%4, column n/4; row r rotates left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      shifted[127-32*c -: 32] = {a0, a1, a2, a3};
      mixed[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    result = (last ? shifted : mixed) ^ round_key;
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core, one round per clock, round keys expanded on the fly.
// Optional completed-block counter port blk_cnt when AES_BLK_CNT_EN is defined.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_text,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_text,
  output logic                busy
`ifdef AES_BLK_CNT_EN
  ,output logic [31:0]        blk_cnt
`endif
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = nr_of(KEY_BITS);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
    $fatal(1, "aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end

  state_t       state_q, state_d;
  logic [3:0]   round_q;
  logic [127:0] st_q;
  logic [31:0]  win_q [NK];
  logic [31:0]  ext [NK+4];
  logic [127:0] rkey;
  logic [127:0] round_out;
  logic         last;
  logic         accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: in_ready = rst;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) begin
        in_ready = rst;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) state_d = RUN;
  end

  assign busy = (state_q != IDLE);
  assign last = (round_q == 4'(NR));

  // Window holds w[4(r-1) .. 4(r-1)+NK-1]; four new words extend it, round key is ext[4..7].
  always_comb begin
    int          j;
    logic [31:0] t;
    for (int k = 0; k < NK; k++) ext[k] = win_q[k];
    for (int k = 0; k < 4; k++) begin
      j = 4 * (int'(round_q) - 1) + NK + k;
      t = ext[NK+k-1];
      if (j % NK == 0)                 t = sub_word(rot_word(t)) ^ {rcon(4'(j / NK)), 24'h0};
      else if (NK == 8 && j % NK == 4) t = sub_word(t);
      ext[NK+k] = ext[k] ^ t;
    end
  end

  assign rkey = {ext[4], ext[5], ext[6], ext[7]};

  aes_round_comb u_round (
    .state     (st_q),
    .round_key (rkey),
    .last      (last),
    .result    (round_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= '0;
      round_q   <= '0;
      out_valid <= 1'b0;
      out_text  <= '0;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
    end else begin
      if (state_q == RUN) begin
        st_q    <= round_out;
        round_q <= round_q + 4'd1;
        for (int k = 0; k < NK; k++) win_q[k] <= ext[k+4];
        if (last) begin
          out_text  <= round_out;
          out_valid <= 1'b1;
          round_q   <= '0;
        end
      end
      if (state_q == DONE && out_ready) out_valid <= 1'b0;
      if (accept) begin
        st_q    <= in_text ^ in_key[KEY_BITS-1 -: 128];
        round_q <= 4'd1;
        for (int k = 0; k < NK; k++) win_q[k] <= in_key[KEY_BITS-1-32*k -: 32];
      end
    end
  end

`ifdef AES_BLK_CNT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        blk_cnt_q <= '0;
    else if (out_valid && out_ready) blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: whole-block AES reference model plus per-cycle handshake scoreboard.
module tb_aes_iter_core;

  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT3  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT3  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [127:0] in_text = '0, in_key = '0, out_text;
  logic         v192 = 1'b0, rdy192, ov192, busy192;
  logic         v256 = 1'b0, rdy256, ov256, busy256;
  logic [127:0] ot192, ot256;
`ifdef AES_BLK_CNT_EN
  logic [31:0]  blk_cnt, bc192, bc256;
`endif

  aes_iter_core #(.KEY_BITS(128)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text),
    .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
    .busy(busy)
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  aes_iter_core #(.KEY_BITS(192)) dut192 (
    .clk(clk), .rst(rst), .in_valid(v192), .in_ready(rdy192), .in_text(PT1),
    .in_key(K192), .out_valid(ov192), .out_ready(1'b1), .out_text(ot192), .busy(busy192)
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(bc192)
`endif
  );

  aes_iter_core #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst), .in_valid(v256), .in_ready(rdy256), .in_text(PT1),
    .in_key(K256), .out_valid(ov256), .out_ready(1'b1), .out_text(ot256), .busy(busy256)
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(bc256)
`endif
  );

  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chkb(input string nm, input logic act, input logic exp);
    chk(nm, {127'd0, act}, {127'd0, exp});
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] sb_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb_t[x] = s;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]};
  endfunction

  // key left-aligned in 256 bits
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] key, input int kb);
    logic [31:0] w [60];
    logic [7:0]  s [16];
    logic [7:0]  tmp [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] t;
    logic [127:0] res;
    int nk, nr;
    nk = kb / 32;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) tmp[n] = sb_t[s[n]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = tmp[4*((c+q)%4)+q];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] ^= w[4*r + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  // ---------------- per-cycle scoreboard for the 128-bit core ----------------
  bit           m_inflight = 0, m_valid = 0, exp_ir;
  int           m_remain = 0;
  logic [127:0] m_res = '0, m_text = '0;
  logic [31:0]  m_cnt = '0;
  bit           p_rst = 0, p_inv = 0, p_ir = 0, p_ordy = 0;
  logic [127:0] p_text = '0, p_key = '0;

  always @(negedge clk) begin
    if (!rst) begin
      m_inflight = 0; m_valid = 0; m_text = '0; m_cnt = '0;
    end else if (p_rst) begin
      if (m_valid && p_ordy) begin
        m_valid = 0;
        m_cnt   = m_cnt + 32'd1;
      end
      if (m_inflight) begin
        m_remain--;
        if (m_remain == 0) begin
          m_inflight = 0; m_valid = 1; m_text = m_res;
        end
      end
      if (p_inv && p_ir) begin
        m_inflight = 1;
        m_remain   = 10;
        m_res      = aes_model(p_text, {p_key, 128'h0}, 128);
      end
    end
    exp_ir = rst && ((!m_inflight && !m_valid) || (m_valid && out_ready));
    chkb("out_valid", out_valid, m_valid);
    chk("out_text", out_text, m_text);
    chkb("busy", busy, m_inflight || m_valid);
    chkb("in_ready", in_ready, exp_ir);
`ifdef AES_BLK_CNT_EN
    chk("blk_cnt", {96'd0, blk_cnt}, {96'd0, m_cnt});
`endif
    p_rst = rst; p_inv = in_valid; p_ir = exp_ir; p_ordy = out_ready;
    p_text = in_text; p_key = in_key;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] t, input logic [127:0] k);
    bit ok = 0;
    in_text = t; in_key = k; in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chkb("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    bit seen = 0;
    lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chkb("out_valid_timeout", 1'b0, 1'b1);
    else lat = cyc - acc_cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c1, c2, n_acc, l192, l256, lo_cnt;
    logic [127:0] t1, t2;
    build_sbox();
    chk("model_sbox_00", {120'd0, sb_t[0]}, 128'h63);
    chk("model_sbox_53", {120'd0, sb_t[8'h53]}, 128'hed);
    chk("model_128", aes_model(PT1, {K1, 128'h0}, 128), CT1);
    chk("model_192", aes_model(PT1, {K192, 64'h0}, 192), CT192);
    chk("model_256", aes_model(PT1, K256, 256), CT256);
    chk("model_fips_b", aes_model(PT3, {K3, 128'h0}, 128), CT3);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // vector 1, AES-128
    send(PT1, K1);
    wait_out(lat);
    chk("t1_latency", 128'(lat), 128'd10);
    chk("t1_text", out_text, CT1);

    // AES-192 and AES-256 instances in parallel
    v192 = 1'b1; v256 = 1'b1; l192 = -1; l256 = -1;
    @(negedge clk);
    chkb("t2_ready192", rdy192, 1'b1);
    chkb("t2_ready256", rdy256, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc = cyc; v192 = 1'b0; v256 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ov192 && l192 < 0) begin l192 = cyc - acc_cyc; t1 = ot192; end
      if (ov256 && l256 < 0) begin l256 = cyc - acc_cyc; t2 = ot256; end
    end
    chk("t2_latency192", 128'(l192), 128'd12);
    chk("t2_text192", t1, CT192);
    chk("t2_latency256", 128'(l256), 128'd14);
    chk("t2_text256", t2, CT256);
    @(posedge clk);
    #1;

    // vector 3 with output back-pressure
    out_ready = 1'b0;
    send(PT3, K3);
    in_text = PT1; in_key = K1;
    wait_out(lat);
    chk("t3_latency", 128'(lat), 128'd10);
    repeat (5) begin
      @(negedge clk);
      chkb("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_text", out_text, CT3);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 chkb("t3_retired", out_valid, 1'b0);

    // back-to-back: vector 1 then vector 3
    in_text = PT1; in_key = K1; in_valid = 1'b1;
    c1 = -1; c2 = -1; n_acc = 0;
    for (int i = 0; i < 60 && c2 < 0; i++) begin
      @(negedge clk);
      if (out_valid && c1 < 0) begin
        c1 = cyc; t1 = out_text;
        chkb("t4_ready_in_done", in_ready, 1'b1);
      end else if (out_valid && c2 < 0) begin
        c2 = cyc; t2 = out_text;
      end
      if (in_ready && in_valid) n_acc++;
      @(posedge clk);
      #1;
      if (n_acc == 1) begin in_text = PT3; in_key = K3; end
      if (n_acc >= 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("t4_interval", 128'(c2 - c1), 128'd11);
    chk("t4_text1", t1, CT1);
    chk("t4_text2", t2, CT3);
    @(posedge clk);
    #1;

    // reset during round 4
    send(PT1, K1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chkb("t5_rst_out_valid", out_valid, 1'b0);
    chkb("t5_rst_busy", busy, 1'b0);
    chkb("t5_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    lo_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) lo_cnt++;
    end
    chk("t5_no_output", 128'(lo_cnt), 128'd0);
    @(posedge clk);
    #1;
    send(PT1, K1);
    wait_out(lat);
    chk("t5_latency", 128'(lat), 128'd10);
    chk("t5_text", out_text, CT1);

`ifdef AES_BLK_CNT_EN
    send(PT3, K3);
    wait_out(lat);
    send(PT1, K1);
    wait_out(lat);
    @(negedge clk);
    chk("t6_blk_cnt_3", {96'd0, blk_cnt}, 128'd3);
    @(posedge clk);
    #1;
    force dut.blk_cnt_q = 32'hffffffff;
    m_cnt = 32'hffffffff;
    #1 release dut.blk_cnt_q;
    send(PT1, K1);
    wait_out(lat);
    @(negedge clk);
    chk("t6_blk_cnt_wrap", {96'd0, blk_cnt}, 128'd0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
